conv_serial_scheduler: RTL and testbench

//  Sequences the bit-serial CIM convolution core for one frame of NUM_WIN windows.
//  Per window: accepts a 32-lane IFM vector (parallel words), shifts it LSB-first onto the

---
 rtl/conv_serial_scheduler.sv | 130 +++++++++++++
 tb/tb_conv_serial_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_serial_scheduler.sv
// conv_serial_scheduler: feeds one frame of IFM vectors bit-serially into the CIM core
// and returns each captured OFM through a valid/ready result port.
module conv_serial_scheduler #(
    parameter int LANES    = 32,
    parameter int IFM_BITS = 8,
    parameter int OFM_W    = 13,
    parameter int WIN_W    = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIN_W-1:0]          cfg_num_win,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANES*IFM_BITS-1:0] s_ifm,
    output logic                      conv_in_valid,
    output logic [LANES-1:0]          conv_ifm,
    input  logic                      conv_out_valid,
    input  logic [OFM_W-1:0]          conv_ofm,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [OFM_W-1:0]          m_ofm,
    output logic                      m_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout
);
    localparam int BW = $clog2(IFM_BITS);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WAIT, HOLD, DONE} state_t;
    state_t                    state;
    logic [LANES*IFM_BITS-1:0] sr;
    logic [BW-1:0]             bit_cnt;
    logic [TW-1:0]             wait_cnt;
    logic [WIN_W-1:0]          win_cnt;
    logic [WIN_W-1:0]          num_win;
    logic                      last_win;
    assign last_win = win_cnt == num_win - WIN_W'(1);
    function automatic logic [LANES-1:0] lsbs(input logic [LANES*IFM_BITS-1:0] v);
        logic [LANES-1:0] r;
        for (int k = 0; k < LANES; k++) r[k] = v[k*IFM_BITS];
        return r;
    endfunction
    // Shifting the whole vector right lets each lane's bit i reach its lane LSB after i shifts;
    // bits leaking across lane boundaries only land above the bits still to be sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sr            <= '0;
            bit_cnt       <= '0;
            wait_cnt      <= '0;
            win_cnt       <= '0;
            num_win       <= '0;
            s_ready       <= 1'b0;
            conv_in_valid <= 1'b0;
            conv_ifm      <= '0;
            m_valid       <= 1'b0;
            m_ofm         <= '0;
            m_last        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    err_timeout <= 1'b0;
                    num_win     <= cfg_num_win;
                    win_cnt     <= '0;
                    busy        <= 1'b1;
                    if (cfg_num_win == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: if (s_valid) begin
                    s_ready       <= 1'b0;
                    sr            <= s_ifm >> 1;
                    conv_ifm      <= lsbs(s_ifm);
                    conv_in_valid <= 1'b1;
                    bit_cnt       <= '0;
                    state         <= SHIFT;
                end
                SHIFT: if (bit_cnt == BW'(IFM_BITS - 1)) begin
                    conv_in_valid <= 1'b0;
                    conv_ifm      <= '0;
                    wait_cnt      <= '0;
                    state         <= WAIT;
                end else begin
                    conv_ifm <= lsbs(sr);
                    sr       <= sr >> 1;
                    bit_cnt  <= bit_cnt + BW'(1);
                end
                WAIT: if (conv_out_valid) begin
                    m_ofm   <= conv_ofm;
                    m_valid <= 1'b1;
                    m_last  <= last_win;
                    state   <= HOLD;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    err_timeout <= 1'b1;
                    done        <= 1'b1;
                    state       <= DONE;
                end else begin
                    wait_cnt <= wait_cnt + TW'(1);
                end
                HOLD: if (m_ready) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    win_cnt <= win_cnt + WIN_W'(1);
                    if (last_win) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= LOAD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_serial_scheduler.sv
// tb_conv_serial_scheduler: directed frames plus randomized traffic, every output compared
// each cycle against a phase/queue model of the scheduler.
module tb_conv_serial_scheduler;
    localparam int LANES = 32, IFM_BITS = 8, OFM_W = 13, WIN_W = 8, TIMEOUT = 64;
    localparam int P_IDLE = 0, P_LOAD = 1, P_SHIFT = 2, P_WAIT = 3, P_HOLD = 4, P_DONE = 5;
    logic clk = 1'b0;
    logic rst, start, s_valid, conv_out_valid, m_ready;
    logic [WIN_W-1:0] cfg_num_win;
    logic [LANES*IFM_BITS-1:0] s_ifm;
    logic [OFM_W-1:0] conv_ofm, m_ofm;
    logic s_ready, conv_in_valid, m_valid, m_last, busy, done, err_timeout;
    logic [LANES-1:0] conv_ifm;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    conv_serial_scheduler #(.LANES(LANES), .IFM_BITS(IFM_BITS), .OFM_W(OFM_W), .WIN_W(WIN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_win(cfg_num_win),
        .s_valid(s_valid), .s_ready(s_ready), .s_ifm(s_ifm),
        .conv_in_valid(conv_in_valid), .conv_ifm(conv_ifm),
        .conv_out_valid(conv_out_valid), .conv_ofm(conv_ofm),
        .m_valid(m_valid), .m_ready(m_ready), .m_ofm(m_ofm), .m_last(m_last),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: frame phase, a queue of serial bit slices still to send, and WAIT age.
    int ph = P_IDLE, age = 0, win = 0, nw = 0;
    bit err = 1'b0;
    logic [OFM_W-1:0] ofm = '0;
    logic [LANES-1:0] slice;
    logic [LANES-1:0] bitq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = P_IDLE; err = 1'b0; ofm = '0; age = 0; win = 0; nw = 0;
            bitq.delete();
        end else begin
            case (ph)
                P_IDLE: if (start) begin
                    err = 1'b0; nw = int'(cfg_num_win); win = 0;
                    ph = (nw == 0) ? P_DONE : P_LOAD;
                end
                P_LOAD: if (s_valid) begin
                    for (int i = 0; i < IFM_BITS; i++) begin
                        for (int k = 0; k < LANES; k++) slice[k] = s_ifm[k*IFM_BITS + i];
                        bitq.push_back(slice);
                    end
                    ph = P_SHIFT;
                end
                P_SHIFT: begin
                    void'(bitq.pop_front());
                    if (bitq.size() == 0) begin ph = P_WAIT; age = 0; end
                end
                P_WAIT: if (conv_out_valid) begin
                    ofm = conv_ofm; ph = P_HOLD;
                end else if (age == TIMEOUT - 1) begin
                    err = 1'b1; ph = P_DONE;
                end else age++;
                P_HOLD: if (m_ready) begin
                    win++;
                    ph = (win == nw) ? P_DONE : P_LOAD;
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, ph != P_IDLE);
        chk("s_ready", s_ready, ph == P_LOAD);
        chk("conv_in_valid", conv_in_valid, ph == P_SHIFT);
        chk("conv_ifm", conv_ifm, (ph == P_SHIFT) ? bitq[0] : '0);
        chk("m_valid", m_valid, ph == P_HOLD);
        chk("m_ofm", m_ofm, ofm);
        chk("m_last", m_last, ph == P_HOLD && win == nw - 1);
        chk("done", done, ph == P_DONE);
        chk("err_timeout", err_timeout, err);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*IFM_BITS-1:0] rand_vec();
        logic [LANES*IFM_BITS-1:0] r;
        for (int k = 0; k < LANES*IFM_BITS/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic wait_s_ready();
        int n = 0;
        while (!s_ready && n < 40) begin tick(); n++; end
        chk("s_ready_wait", s_ready, 1);
    endtask

    // Hand over one vector and ride out the serial burst; returns lane 0 bits as sent.
    task automatic to_wait(input logic [LANES*IFM_BITS-1:0] d, output logic [IFM_BITS-1:0] l0);
        s_ifm = d; s_valid = 1'b1;
        wait_s_ready();
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < IFM_BITS; i++) begin
            chk("shift_valid", conv_in_valid, 1);
            l0[i] = conv_ifm[0];
            tick();
        end
        chk("shift_end", conv_in_valid, 0);
    endtask

    task automatic run_window(input logic [LANES*IFM_BITS-1:0] d, input logic [OFM_W-1:0] v,
                              input int holdn, input bit exp_last, output logic [IFM_BITS-1:0] l0);
        to_wait(d, l0);
        conv_out_valid = 1'b1; conv_ofm = v;
        tick();
        conv_out_valid = 1'b0;
        for (int i = 0; i < holdn; i++) begin
            chk("hold_ofm", m_ofm, v);
            chk("hold_s_ready", s_ready, 0);
            tick();
        end
        chk("res_valid", m_valid, 1);
        chk("res_ofm", m_ofm, v);
        chk("res_last", m_last, exp_last);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic go(input int n);
        start = 1'b1; cfg_num_win = WIN_W'(n);
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [IFM_BITS-1:0] b;
        logic [LANES*IFM_BITS-1:0] d;
        int pcov;
        rst = 1'b1; start = 1'b0; cfg_num_win = '0; s_valid = 1'b0; s_ifm = '0;
        conv_out_valid = 1'b0; conv_ofm = '0; m_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_civ", conv_in_valid, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mofm", m_ofm, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;
        tick();
        // single window, lane0 = A5
        go(1);
        d = '0; d[7:0] = 8'hA5;
        run_window(d, 13'h0123, 0, 1'b1, b);
        chk("t1_lane0_bits", b, 8'hA5);
        chk("t1_done", done, 1);
        tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_done_low", done, 0);
        // four windows with a slow consumer
        go(4);
        for (int w = 0; w < 4; w++) run_window(rand_vec(), OFM_W'(100 + w), 5, w == 3, b);
        chk("t2_done", done, 1);
        tick();
        chk("t2_busy", busy, 0);
        // timeout, then a start clears the sticky error
        go(2);
        to_wait(rand_vec(), b);
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("t3_no_err_yet", err_timeout, 0);
            tick();
        end
        chk("t3_err", err_timeout, 1);
        chk("t3_done", done, 1);
        tick();
        chk("t3_busy", busy, 0);
        chk("t3_err_sticky", err_timeout, 1);
        go(1);
        chk("t3_err_cleared", err_timeout, 0);
        run_window(rand_vec(), 13'h0777, 0, 1'b1, b);
        tick();
        // out_valid on the last allowed WAIT cycle is captured, no error
        go(1);
        to_wait(rand_vec(), b);
        repeat (TIMEOUT - 1) tick();
        conv_out_valid = 1'b1; conv_ofm = 13'h1ABC;
        tick();
        conv_out_valid = 1'b0;
        chk("tb_edge_mvalid", m_valid, 1);
        chk("tb_edge_ofm", m_ofm, 13'h1ABC);
        chk("tb_edge_err", err_timeout, 0);
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        tick();
        // empty frame
        go(0);
        chk("t4_done", done, 1);
        chk("t4_s_ready", s_ready, 0);
        tick();
        chk("t4_done_low", done, 0);
        chk("t4_busy", busy, 0);
        // async reset in the third shift cycle
        go(1);
        s_ifm = {LANES*IFM_BITS/32{32'hFFFF_FFFF}}; s_valid = 1'b1;
        wait_s_ready();
        tick();
        s_valid = 1'b0;
        tick(); tick();
        chk("t5_shifting", conv_in_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_civ_drop", conv_in_valid, 0);
        chk("t5_ifm_zero", conv_ifm, 0);
        chk("t5_busy_drop", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        go(1);
        d = '0; d[15:8] = 8'h3C;
        run_window(d, 13'h0042, 0, 1'b1, b);
        tick();
        // stray out_valid while shifting, start while holding
        go(1);
        s_ifm = rand_vec(); s_valid = 1'b1;
        wait_s_ready();
        tick();
        s_valid = 1'b0; conv_out_valid = 1'b1; conv_ofm = 13'h1FFF;
        repeat (IFM_BITS) tick();
        conv_ofm = 13'h00AB;
        tick();
        conv_out_valid = 1'b0;
        start = 1'b1; cfg_num_win = 8'd7;
        tick();
        start = 1'b0;
        chk("t6_ofm", m_ofm, 13'h00AB);
        chk("t6_last", m_last, 1);
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("t6_done", done, 1);
        tick();
        chk("t6_idle", busy, 0);
        // randomized traffic
        pcov = 5;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) pcov = ($urandom_range(0, 2) == 0) ? 0 : ($urandom_range(0, 1) ? 5 : 40);
            start          = ($urandom_range(0, 9) == 0);
            cfg_num_win    = WIN_W'($urandom_range(0, 4));
            s_valid        = $urandom_range(0, 1) == 1;
            s_ifm          = rand_vec();
            conv_out_valid = $urandom_range(0, 99) < pcov;
            conv_ofm       = OFM_W'($urandom);
            m_ready        = $urandom_range(0, 2) != 0;
            rst            = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; conv_out_valid = 1'b0; m_ready = 1'b0;
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
